rr_encode_arbiter: RTL
======================

RR_ENCODE_ARBITER -- requirements
Module: rr_encode_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 15, maximum grant length in cycles before a forced release (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req, input, 4, one request line per requester; bit i belongs to requester i.
REQ-005 SHALL have port done, input, 1, release pulse from the current grant owner.
REQ-006 SHALL have port gnt, output, 4, one-hot registered grant vector.
REQ-007 SHALL have port gnt_idx, output, 2, binary encoding of the gnt bit that is set (4-to-2 encode).
REQ-008 SHALL have port gnt_valid, output, 1, high exactly when gnt is nonzero.
REQ-009 SHALL have port timeout, output, 1, one-cycle pulse marking a forced release.

Function
REQ-010 SHALL implement the FSM states IDLE, GRANT and RELEASE.
REQ-011 SHALL keep a 2-bit round-robin pointer ptr and a hold counter hold_cnt of width ceil(log2(MAX_HOLD)).
REQ-012 In IDLE with req nonzero, SHALL choose the first set req bit when scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-013 On the same edge as REQ-012, SHALL enter GRANT, set gnt to the winner's one-hot value, set gnt_idx to the winner index, set gnt_valid to 1 and clear hold_cnt, giving a latency of 1 cycle from sampled req to grant.
REQ-014 In IDLE with req equal to 0, SHALL remain in IDLE with gnt=0, gnt_idx=0 and gnt_valid=0.
REQ-015 In GRANT, SHALL hold gnt and gnt_idx constant and ignore changes on the req bits of non-owners.
REQ-016 In GRANT, SHALL increment hold_cnt by 1 every cycle.
REQ-017 SHALL release the grant when any of the following is true: done=1; req[gnt_idx]=0; or hold_cnt=MAX_HOLD-1.
REQ-018 On a release, SHALL enter RELEASE, clear gnt, gnt_idx and gnt_valid, and set ptr to gnt_idx+1 modulo 4 (3 wraps to 0).
REQ-019 SHALL assert timeout for the single RELEASE cycle only when the release was caused solely by the hold_cnt limit.
REQ-020 If done or the owner's req drop coincides with the hold_cnt limit, SHALL treat the release as a normal release with timeout=0.
REQ-021 SHALL leave RELEASE for IDLE unconditionally after 1 cycle, giving 1 dead cycle with no grant between owners.
REQ-022 SHALL ignore done whenever the FSM is not in GRANT.
REQ-023 SHALL guarantee that gnt never has more than one bit set and that gnt_idx always matches gnt.
REQ-024 SHALL bound a continuously requesting requester's wait to 3 complete grants of other requesters.

Reset
REQ-025 While rst_n=0, SHALL asynchronously force state=IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_idx=0, gnt_valid=0 and timeout=0.
REQ-026 SHALL apply REQ-025 immediately on reset assertion in any state, including mid-grant, with no RELEASE cycle and no timeout pulse.
REQ-027 After rst_n deasserts, SHALL arbitrate on the first rising clock edge using ptr=0.

Verification
REQ-028 Single request: req=4'b1000, done pulsed 3 cycles after grant -> gnt=4'b1000 and gnt_idx=3 one cycle after req; then 1 RELEASE cycle; ptr becomes 0.
REQ-029 Rotation: req=4'b1111 held, each owner pulses done after 2 cycles -> grant order 0, 1, 2, 3, 0, with 1 dead cycle between grants.
REQ-030 Timeout: MAX_HOLD=4, req=4'b0010 held, done never pulsed -> gnt=4'b0010 for exactly 4 cycles, then timeout=1 for 1 cycle, then gnt re-granted to 1 after IDLE.
REQ-031 Coincidence: MAX_HOLD=4, done pulsed on the 4th grant cycle -> release with timeout=0.
REQ-032 Owner drop: req=4'b0101 granted to 0, req[0] dropped -> next edge gnt=0; after the dead cycle, gnt=4'b0100 and gnt_idx=2.
REQ-033 Mid-grant reset: rst_n pulled low during a grant to requester 2 -> gnt=0 immediately; after release with req=4'b1111, the first grant goes to 0.

Source files
------------

// File: rtl/rr_encode_arbiter.sv
// Four-requester round-robin arbiter with a registered one-hot grant, its binary
// index, a hold-time limit that forces release, and one dead RELEASE cycle per handoff.
module rr_encode_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        gnt_idx_q, gnt_idx_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              timeout_q, timeout_d;

  // Rotating priority scan: the first set request at or after ptr wins.
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       found;

  always_comb begin
    win_idx = 2'd0;
    cand    = 2'd0;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + k[1:0];
      if (!found && req[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  logic owner_drop;
  logic at_limit;

  assign owner_drop = !req[gnt_idx_q];
  assign at_limit   = (hold_cnt_q == HOLD_LAST);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = GRANT;
          gnt_d       = 4'b0001 << win_idx;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end else begin
          gnt_d       = 4'b0000;
          gnt_idx_d   = 2'd0;
          gnt_valid_d = 1'b0;
        end
      end

      GRANT: begin
        if (done || owner_drop || at_limit) begin
          state_d     = RELEASE;
          ptr_d       = gnt_idx_q + 2'd1;
          gnt_d       = 4'b0000;
          gnt_idx_d   = 2'd0;
          gnt_valid_d = 1'b0;
          // A limit hit that coincides with a voluntary release is not a timeout.
          timeout_d   = at_limit && !done && !owner_drop;
        end else begin
          hold_cnt_d  = hold_cnt_q + 1'b1;
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        gnt_d       = 4'b0000;
        gnt_idx_d   = 2'd0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      hold_cnt_q  <= '0;
      gnt_q       <= 4'b0000;
      gnt_idx_q   <= 2'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
